// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the program-counter / fetch stage.
//   fetch_state_t - sequencing states (IDLE, RUN, HALT)
//   PC_W_DEF      - default program-counter width
//   CNT_W_DEF     - default performance-counter width
//   kPC_*         - PCRegSelect encodings
package pc_fetch_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] kPC_NONE = 2'b00;
    localparam logic [1:0] kPC_R1   = 2'b01;
    localparam logic [1:0] kPC_R2   = 2'b10;
    localparam logic [1:0] kPC_R3   = 2'b11;

endpackage

// File: rtl/pc_perf_cnt.sv
// pc_perf_cnt: saturating up-counter with synchronous clear.
//   clk  - clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear, has priority over inc
//   inc  - count enable; holds at all-ones once reached
//   cnt  - counter value
module pc_perf_cnt
    import pc_fetch_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencing upstream of the control decoder.
// Holds ProgCtr, three saved-address registers and the zero flag; executes the
// decoder's save/jump requests and the Start/run/halt handshake.
//
// Optional feature: define PC_PERF_CNT_EN to build the cycle / taken-jump
// performance counters. Without it CycleCnt and TakenCnt are tied to 0.
//
// Ports:
//   Clk, Reset    - clock, asynchronous active-high reset
//   Start         - hold PC at 0 (IDLE) while high, run once low
//   Ack           - halt instruction decoded
//   JumpEqual     - je decoded (wins over JumpNotEqual)
//   JumpNotEqual  - jne decoded
//   OffsetEn      - add Offset to the saved address
//   PCRegSelect   - 00 none, 01/10/11 saved-address register 1/2/3
//   Offset        - zero-extended offset for saves
//   ZeroIn        - ALU zero result
//   FlagWrEn      - current instruction updates the zero flag
//   ProgCtr       - registered instruction-ROM address
//   Done          - registered, high in HALT
//   CycleCnt      - RUN cycles executed (saturating)
//   TakenCnt      - taken jumps (saturating)
//
// state | meaning
// IDLE  | held by Start, PC = 0; leaves to RUN once Start is low
// RUN   | executing one instruction per cycle
// HALT  | halt decoded, everything frozen until Start
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic [7:0]       Offset,
    input  logic             ZeroIn,
    input  logic             FlagWrEn,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] TakenCnt
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    // Entry 0 is never written; PCRegSelect = 00 means "no register".
    logic [PC_W-1:0] pcreg_q [4];
    logic [PC_W-1:0] pcreg_d [4];
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic            run_cycle;
    logic            jump_taken;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] offset_ext;
    logic            jump_req;
    logic            jump_cond;

    // Address sums wrap modulo 2^PC_W through truncation.
    assign pc_inc     = pc_q + PC_W'(1);
    assign offset_ext = PC_W'(Offset);
    assign jump_req   = JumpEqual | JumpNotEqual;
    // The condition uses the flag registered before this edge, not ZeroIn.
    assign jump_cond  = JumpEqual ? zero_q : ~zero_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pcreg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            for (int i = 0; i < 4; i++) begin
                pcreg_q[i] <= pcreg_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pcreg_d    = pcreg_q;
        zero_d     = zero_q;
        done_d     = done_q;
        run_cycle  = 1'b0;
        jump_taken = 1'b0;

        if (Start) begin
            state_d = IDLE;
            pc_d    = '0;
            zero_d  = 1'b0;
            done_d  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pcreg_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    run_cycle = 1'b1;
                    if (FlagWrEn) begin
                        zero_d = ZeroIn;
                    end
                    if (Ack) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end else if (jump_req && (PCRegSelect != kPC_NONE)) begin
                        if (jump_cond) begin
                            pc_d       = pcreg_q[PCRegSelect];
                            jump_taken = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end else if (jump_req) begin
                        pc_d = pc_inc;
                    end else begin
                        if (PCRegSelect != kPC_NONE) begin
                            pcreg_d[PCRegSelect] = OffsetEn ? (pc_inc + offset_ext) : pc_inc;
                        end
                        pc_d = pc_inc;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ProgCtr = pc_q;
    assign Done    = done_q;

`ifdef PC_PERF_CNT_EN
    pc_perf_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk (Clk),
        .rst (Reset),
        .clr (Start),
        .inc (run_cycle),
        .cnt (CycleCnt)
    );

    pc_perf_cnt #(.W(CNT_W)) u_taken_cnt (
        .clk (Clk),
        .rst (Reset),
        .clr (Start),
        .inc (jump_taken),
        .cnt (TakenCnt)
    );
`else
    logic unused_perf;
    assign unused_perf = run_cycle | jump_taken;
    assign CycleCnt    = '0;
    assign TakenCnt    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch with an architectural reference model.
module tb_pc_fetch;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset, Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, ZeroIn, FlagWrEn;
    logic [1:0]       PCRegSelect;
    logic [7:0]       Offset;
    logic [PC_W-1:0]  ProgCtr;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt, TakenCnt;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural state as plain integers.
    int m_pc, m_zero, m_done, m_mode, m_cyc, m_tkn;   // m_mode: 0 idle, 1 run, 2 halted
    int m_reg [4];

    always #5 Clk = ~Clk;

    pc_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Ack          (Ack),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .OffsetEn     (OffsetEn),
        .PCRegSelect  (PCRegSelect),
        .Offset       (Offset),
        .ZeroIn       (ZeroIn),
        .FlagWrEn     (FlagWrEn),
        .ProgCtr      (ProgCtr),
        .Done         (Done),
        .CycleCnt     (CycleCnt),
        .TakenCnt     (TakenCnt)
    );

    function automatic int exp_cyc();
        return PERF ? m_cyc : 0;
    endfunction

    function automatic int exp_tkn();
        return PERF ? m_tkn : 0;
    endfunction

    task automatic model_clear();
        m_pc = 0; m_zero = 0; m_done = 0; m_mode = 0; m_cyc = 0; m_tkn = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
    endtask

    // One rising edge of behaviour, from the current input values.
    task automatic model_step();
        int  nxt;
        int  old_zero;
        bit  jump;
        bit  cond;
        nxt = (m_pc + 1) % PC_MOD;
        if (Reset || Start) begin
            model_clear();
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            old_zero = m_zero;
            if (FlagWrEn) m_zero = ZeroIn;
            if (m_cyc < CNT_MAX) m_cyc++;
            jump = JumpEqual || JumpNotEqual;
            if (Ack) begin
                m_mode = 2;
                m_done = 1;
            end else if (jump && PCRegSelect != 0) begin
                cond = JumpEqual ? (old_zero == 1) : (old_zero == 0);
                if (cond) begin
                    m_pc = m_reg[PCRegSelect];
                    if (m_tkn < CNT_MAX) m_tkn++;
                end else begin
                    m_pc = nxt;
                end
            end else if (jump) begin
                m_pc = nxt;
            end else begin
                if (PCRegSelect != 0)
                    m_reg[PCRegSelect] = (nxt + (OffsetEn ? int'(Offset) : 0)) % PC_MOD;
                m_pc = nxt;
            end
        end
    endtask

    task automatic set_in(input bit st, input bit ak, input bit je, input bit jne,
                          input bit oe, input logic [1:0] sel, input logic [7:0] off,
                          input bit zi, input bit fw);
        Start = st; Ack = ak; JumpEqual = je; JumpNotEqual = jne; OffsetEn = oe;
        PCRegSelect = sel; Offset = off; ZeroIn = zi; FlagWrEn = fw;
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int exp_seq [3] = '{0, 1, 2};
        Reset = 1'b1;
        set_in(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        #2;
        model_clear();
        checks++;
        if (ProgCtr !== '0 || Done !== 1'b0 || CycleCnt !== '0 || TakenCnt !== '0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d done=%0d cyc=%0d tkn=%0d, want all 0",
                     ProgCtr, Done, CycleCnt, TakenCnt);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (ProgCtr !== 10'd0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL start_hold[%0d]: pc=%0d done=%0d, want pc=0 done=0", i, ProgCtr, Done);
            end
        end
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (ProgCtr !== PC_W'(exp_seq[i]) || Done !== 1'b0) begin
                errors++;
                $display("FAIL start_run[%0d]: pc=%0d done=%0d, want pc=%0d done=0",
                         i, ProgCtr, Done, exp_seq[i]);
            end
        end
    endtask

    task automatic test_save_jump();
        int budget = 20;
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        while (ProgCtr != 10'd5 && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (ProgCtr !== 10'd5) begin
            errors++;
            $display("FAIL reach_pc5: pc=%0d, want 5", ProgCtr);
        end
        // spc r2 with offset 7 at pc 5 -> r2 = 13
        set_in(0, 0, 0, 0, 1, 2'b10, 8'h07, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd6) begin
            errors++;
            $display("FAIL save_offset_pc: pc=%0d, want 6", ProgCtr);
        end
        // set Zero = 1, then je r2 -> 13
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 1);
        cycle();
        set_in(0, 0, 1, 0, 0, 2'b10, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd13 || TakenCnt !== CNT_W'(exp_tkn())) begin
            errors++;
            $display("FAIL je_taken: pc=%0d tkn=%0d, want pc=13 tkn=%0d", ProgCtr, TakenCnt, exp_tkn());
        end
        // spc r2 without offset at 13 -> r2 = 14
        set_in(0, 0, 0, 0, 0, 2'b10, 8'h55, 0, 0);
        cycle();
        // Zero = 0, then je r2 not taken: 15 -> 16
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 1);
        cycle();
        set_in(0, 0, 1, 0, 0, 2'b10, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd16) begin
            errors++;
            $display("FAIL je_not_taken: pc=%0d, want 16", ProgCtr);
        end
        // jne with simultaneous flag write of 1: old Zero=0 decides -> taken to 14
        set_in(0, 0, 0, 1, 0, 2'b10, 8'h00, 1, 1);
        cycle();
        checks++;
        if (ProgCtr !== 10'd14) begin
            errors++;
            $display("FAIL flag_timing_jne: pc=%0d, want 14", ProgCtr);
        end
        // Zero now reads 1: je (with jne also high, je wins) -> taken to 14
        set_in(0, 0, 1, 1, 0, 2'b10, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd14 || TakenCnt !== CNT_W'(exp_tkn()) || CycleCnt !== CNT_W'(exp_cyc())) begin
            errors++;
            $display("FAIL zero_after_write: pc=%0d tkn=%0d cyc=%0d, want pc=14 tkn=%0d cyc=%0d",
                     ProgCtr, TakenCnt, CycleCnt, exp_tkn(), exp_cyc());
        end
        // jump request with select 00 is a plain increment
        set_in(0, 0, 1, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd15) begin
            errors++;
            $display("FAIL jump_sel_none: pc=%0d, want 15", ProgCtr);
        end
    endtask

    task automatic test_halt_wrap();
        int budget = 1100;
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        while (ProgCtr != 10'd1021 && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (ProgCtr !== 10'd1021) begin
            errors++;
            $display("FAIL reach_pc1021: pc=%0d, want 1021", ProgCtr);
        end
        set_in(0, 0, 0, 0, 1, 2'b01, 8'hFF, 0, 0);   // r1 = (1022+255) mod 1024 = 253
        cycle();
        set_in(0, 0, 0, 0, 0, 2'b11, 8'h00, 0, 0);   // r3 = 1023
        cycle();
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 1, 1);   // 1023 -> 0, Zero = 1
        cycle();
        checks++;
        if (ProgCtr !== 10'd0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%0d, want 0", ProgCtr);
        end
        set_in(0, 0, 1, 0, 0, 2'b01, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd253) begin
            errors++;
            $display("FAIL offset_wrap_jump: pc=%0d, want 253", ProgCtr);
        end
        set_in(0, 0, 1, 0, 0, 2'b11, 8'h00, 0, 0);
        cycle();
        set_in(0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'h3FF || Done !== 1'b1) begin
            errors++;
            $display("FAIL halt_entry: pc=%0d done=%0d, want pc=1023 done=1", ProgCtr, Done);
        end
        for (int i = 0; i < 10; i++) begin
            set_in(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            cycle();
            checks++;
            if (ProgCtr !== 10'h3FF || Done !== 1'b1 || CycleCnt !== CNT_W'(exp_cyc())
                || TakenCnt !== CNT_W'(exp_tkn())) begin
                errors++;
                $display("FAIL halt_hold[%0d]: pc=%0d done=%0d cyc=%0d tkn=%0d, want pc=1023 done=1 cyc=%0d tkn=%0d",
                         i, ProgCtr, Done, CycleCnt, TakenCnt, exp_cyc(), exp_tkn());
            end
        end
        set_in(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        checks++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0 || CycleCnt !== '0 || TakenCnt !== '0) begin
            errors++;
            $display("FAIL halt_restart: pc=%0d done=%0d cyc=%0d tkn=%0d, want all 0",
                     ProgCtr, Done, CycleCnt, TakenCnt);
        end
        Start = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            cycle();
            checks++;
            if (ProgCtr !== PC_W'(m_pc) || Done !== 1'(m_done) || CycleCnt !== CNT_W'(exp_cyc())
                || TakenCnt !== CNT_W'(exp_tkn())) begin
                errors++;
                $display("FAIL random[%0d]: pc=%0d done=%0d cyc=%0d tkn=%0d, want pc=%0d done=%0d cyc=%0d tkn=%0d",
                         i, ProgCtr, Done, CycleCnt, TakenCnt, m_pc, m_done, exp_cyc(), exp_tkn());
            end
        end
    endtask

    task automatic test_saturate();
        set_in(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        Start = 1'b0;
        for (int i = 0; i < CNT_MAX + 8; i++) cycle();
        checks++;
        if (CycleCnt !== CNT_W'(exp_cyc()) || ProgCtr !== PC_W'(m_pc)) begin
            errors++;
            $display("FAIL cycle_saturate: cyc=%0d pc=%0d, want cyc=%0d pc=%0d",
                     CycleCnt, ProgCtr, exp_cyc(), m_pc);
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        set_in(0, 1, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (ProgCtr !== '0 || Done !== 1'b0 || CycleCnt !== '0 || TakenCnt !== '0) begin
            errors++;
            $display("FAIL async_reset: pc=%0d done=%0d cyc=%0d tkn=%0d, want all 0",
                     ProgCtr, Done, CycleCnt, TakenCnt);
        end
        model_clear();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        cycle();
        cycle();
        checks++;
        if (ProgCtr !== 10'd1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_run: pc=%0d done=%0d, want pc=1 done=0", ProgCtr, Done);
        end
    endtask

    initial begin
        test_reset();
        test_save_jump();
        test_halt_wrap();
        test_random();
        if (PERF) test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
